// File: rtl/counter_pkg.sv
// Shared constants for the programmable counter slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents: direction/mode encodings and default parameter values used by
// counter_prog and counter_prescaler.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PRESC_W = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits tick once every presc_div+1 enabled cycles.
// Latency: tick is combinational from the prescaler state (same-cycle use).
// Backpressure: none; en=0 freezes the phase, clr restarts it.
//
// Ports: clk, rst (sync, active-high), en (advance), clr (restart phase),
//        presc_div (divide ratio minus one) -> tick.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_hit;

  // ">=" rather than "==" so lowering presc_div mid-period cannot strand
  // the phase above the new terminal value.
  assign w_hit = (r_cnt >= presc_div);
  assign tick  = en & w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_prog.sv
// Programmable-modulus up/down counter with step, load, wrap/saturate, prescaler.
// Latency: count/flags update on the edge where the tick is seen; at_max/at_zero are combinational.
// Backpressure: none; count_en=0 holds count and prescaler phase.
//
// Ports: clk, rst (sync, active-high), count_en, count_clr, count_dir,
//        load_en/load_val, max_val (terminal), step, sat_mode, presc_div
//        -> count, overflow/underflow (1-cycle registered pulses), at_max, at_zero.
module counter_prog
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               count_en,
  input  logic               count_clr,
  input  logic               count_dir,
  input  logic               load_en,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   max_val,
  input  logic [WIDTH-1:0]   step,
  input  logic               sat_mode,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   count,
  output logic               overflow,
  output logic               underflow,
  output logic               at_max,
  output logic               at_zero
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_tick;
  logic             w_presc_clr;

  // All limit arithmetic is one bit wider than the counter so that
  // count+step and max_val+1 never truncate.
  logic [WIDTH:0]   w_cnt;
  logic [WIDTH:0]   w_max;
  logic [WIDTH:0]   w_mod;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_sum_up;
  logic [WIDTH:0]   w_wrap_up;
  logic [WIDTH:0]   w_down;
  logic [WIDTH:0]   w_wrap_dn;
  logic [WIDTH:0]   w_nxt;
  logic             w_ovf;
  logic             w_udf;
  logic [WIDTH-1:0] w_nxt_cnt;
  logic [WIDTH-1:0] w_load;
  logic             w_unused_msb;

  // Load and clear both restart the prescaler phase.
  assign w_presc_clr = count_clr | load_en;

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .rst       (rst),
    .en        (count_en),
    .clr       (w_presc_clr),
    .presc_div (presc_div),
    .tick      (w_tick)
  );

  assign w_cnt     = {1'b0, r_count};
  assign w_max     = {1'b0, max_val};
  assign w_mod     = w_max + {{WIDTH{1'b0}}, 1'b1};
  assign w_step    = {1'b0, step};
  // A step larger than the modulus would wrap more than once; clamp it.
  assign w_s       = (w_step > w_mod) ? w_mod : w_step;
  assign w_sum_up  = w_cnt + w_s;
  assign w_wrap_up = w_sum_up - w_mod;
  assign w_down    = w_cnt - w_s;
  assign w_wrap_dn = w_cnt + w_mod - w_s;

  assign w_load    = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    w_nxt = w_cnt;
    w_ovf = 1'b0;
    w_udf = 1'b0;
    if (w_s == '0) begin
      w_nxt = w_cnt;
    end else if (w_cnt > w_max) begin
      // Only reachable when max_val was lowered below the current count;
      // treated as an overflow whatever the direction.
      w_ovf = 1'b1;
      w_nxt = (sat_mode == MODE_SAT) ? w_max : '0;
    end else if (count_dir == DIR_UP) begin
      if (w_sum_up > w_max) begin
        w_ovf = 1'b1;
        w_nxt = (sat_mode == MODE_SAT) ? w_max : w_wrap_up;
      end else begin
        w_nxt = w_sum_up;
      end
    end else begin
      if (w_s > w_cnt) begin
        w_udf = 1'b1;
        w_nxt = (sat_mode == MODE_SAT) ? '0 : w_wrap_dn;
      end else begin
        w_nxt = w_down;
      end
    end
  end

  // Every branch above yields a value <= max_val, so the top bit is always 0.
  assign w_nxt_cnt    = w_nxt[WIDTH-1:0];
  assign w_unused_msb = w_nxt[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (count_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (load_en) begin
      r_count <= w_load;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (w_tick) begin
      r_count <= w_nxt_cnt;
      r_ovf   <= w_ovf;
      r_udf   <= w_udf;
    end else begin
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end
  end

  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_udf;
  assign at_max    = (r_count == max_val);
  assign at_zero   = (r_count == '0);

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench for counter_prog: directed scenarios plus a randomized
// run against an integer-arithmetic reference model.
module tb_counter_prog;

  logic       clk;
  logic       rst;
  logic       count_en;
  logic       count_clr;
  logic       count_dir;
  logic       load_en;
  logic [7:0] load_val;
  logic [7:0] max_val;
  logic [7:0] step;
  logic       sat_mode;
  logic [3:0] presc_div;
  logic [7:0] count;
  logic       overflow;
  logic       underflow;
  logic       at_max;
  logic       at_zero;

  int n_tests = 0;
  int n_fail  = 0;

  counter_prog #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_en  (count_en),
    .count_clr (count_clr),
    .count_dir (count_dir),
    .load_en   (load_en),
    .load_val  (load_val),
    .max_val   (max_val),
    .step      (step),
    .sat_mode  (sat_mode),
    .presc_div (presc_div),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are changed only after this returns.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load_en = 1'b1; load_val = 8'(v);
    clk_step();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; count_en = 1'b1; count_dir = 1'b1; count_clr = 1'b0; load_en = 1'b0;
    load_val = 8'd0; max_val = 8'd9; step = 8'd1; sat_mode = 1'b0; presc_div = 4'd0;
    clk_step(); clk_step();
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {overflow, underflow}); end
    n_tests++; if (at_zero !== 1'b1) begin n_fail++; $display("FAIL reset_at_zero: got %b expected 1", at_zero); end
    rst = 1'b0;
    clk_step();
    n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL reset_first_tick: got %0d expected 1", count); end
  endtask

  task automatic test_wrap_up();
    int e;
    count_clr = 1'b1; clk_step(); count_clr = 1'b0;
    max_val = 8'd9; step = 8'd1; presc_div = 4'd0; sat_mode = 1'b0; count_dir = 1'b1; count_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clk_step();
      e = i % 10;
      n_tests++; if (count !== 8'(e)) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, e); end
      n_tests++; if (overflow !== (i == 10)) begin n_fail++; $display("FAIL wrap_ovf[%0d]: got %b expected %b", i, overflow, (i == 10)); end
      n_tests++; if (at_max !== (e == 9)) begin n_fail++; $display("FAIL wrap_at_max[%0d]: got %b expected %b", i, at_max, (e == 9)); end
    end
  endtask

  task automatic test_step();
    max_val = 8'd9; step = 8'd3; sat_mode = 1'b0; count_dir = 1'b1; presc_div = 4'd0; count_en = 1'b1;
    do_load(8);
    n_tests++; if (count !== 8'd8) begin n_fail++; $display("FAIL step_load: got %0d expected 8", count); end
    clk_step();
    n_tests++; if ({count, overflow, underflow} !== {8'd1, 2'b10}) begin n_fail++; $display("FAIL step_up_wrap: got %0d/%b%b expected 1/10", count, overflow, underflow); end
    count_dir = 1'b0;
    clk_step();
    n_tests++; if ({count, overflow, underflow} !== {8'd8, 2'b01}) begin n_fail++; $display("FAIL step_dn_wrap: got %0d/%b%b expected 8/01", count, overflow, underflow); end
    step = 8'd15; count_dir = 1'b1;
    clk_step();
    n_tests++; if ({count, overflow, underflow} !== {8'd8, 2'b10}) begin n_fail++; $display("FAIL step_clamp_up: got %0d/%b%b expected 8/10", count, overflow, underflow); end
    count_dir = 1'b0;
    clk_step();
    n_tests++; if ({count, overflow, underflow} !== {8'd8, 2'b01}) begin n_fail++; $display("FAIL step_clamp_dn: got %0d/%b%b expected 8/01", count, overflow, underflow); end
  endtask

  task automatic test_saturate();
    max_val = 8'd200; sat_mode = 1'b1; step = 8'd5; count_dir = 1'b1; count_en = 1'b1; presc_div = 4'd0;
    do_load(198);
    clk_step();
    n_tests++; if ({count, overflow} !== {8'd200, 1'b1}) begin n_fail++; $display("FAIL sat_up: got %0d/%b expected 200/1", count, overflow); end
    n_tests++; if (at_max !== 1'b1) begin n_fail++; $display("FAIL sat_at_max: got %b expected 1", at_max); end
    clk_step();
    n_tests++; if ({count, overflow} !== {8'd200, 1'b1}) begin n_fail++; $display("FAIL sat_repeat: got %0d/%b expected 200/1", count, overflow); end
    do_load(2);
    count_dir = 1'b0;
    clk_step();
    n_tests++; if ({count, underflow, at_zero} !== {8'd0, 2'b11}) begin n_fail++; $display("FAIL sat_dn: got %0d/%b/%b expected 0/1/1", count, underflow, at_zero); end
    sat_mode = 1'b0;
  endtask

  task automatic test_prescaler();
    max_val = 8'd9; step = 8'd1; presc_div = 4'd2; count_dir = 1'b1; sat_mode = 1'b0;
    count_en = 1'b1; count_clr = 1'b1; clk_step(); count_clr = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      clk_step();
      n_tests++; if (count !== 8'(k / 3)) begin n_fail++; $display("FAIL presc_run[%0d]: got %0d expected %0d", k, count, k / 3); end
    end
    count_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clk_step();
      n_tests++; if ({count, overflow} !== {8'd2, 1'b0}) begin n_fail++; $display("FAIL presc_hold[%0d]: got %0d/%b expected 2/0", k, count, overflow); end
    end
    count_en = 1'b1;
    clk_step();
    n_tests++; if (count !== 8'd2) begin n_fail++; $display("FAIL presc_resume1: got %0d expected 2", count); end
    clk_step();
    n_tests++; if (count !== 8'd3) begin n_fail++; $display("FAIL presc_resume2: got %0d expected 3", count); end
    presc_div = 4'd0;
  endtask

  task automatic test_priority();
    max_val = 8'd9; step = 8'd1; count_dir = 1'b1; count_en = 1'b1; sat_mode = 1'b0; presc_div = 4'd0;
    do_load(5);
    count_clr = 1'b1; load_en = 1'b1; load_val = 8'd7;
    clk_step();
    count_clr = 1'b0; load_en = 1'b0;
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL prio_clr_load: got %0d expected 0", count); end
    max_val = 8'd100;
    do_load(250);
    n_tests++; if ({count, at_max} !== {8'd100, 1'b1}) begin n_fail++; $display("FAIL load_clamp: got %0d/%b expected 100/1", count, at_max); end
    max_val = 8'd50;
    clk_step();
    n_tests++; if ({count, overflow} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL lowered_max: got %0d/%b expected 0/1", count, overflow); end
    clk_step(); clk_step();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    n_tests++; if ({count, overflow, underflow} !== {8'd0, 2'b00}) begin n_fail++; $display("FAIL mid_reset: got %0d/%b%b expected 0/00", count, overflow, underflow); end
    // Degenerate modulus: count pinned at zero, every tick is a limit crossing.
    max_val = 8'd0; count_dir = 1'b1;
    clk_step();
    n_tests++; if ({count, overflow, underflow, at_max, at_zero} !== {8'd0, 4'b1011}) begin n_fail++; $display("FAIL max0_up: got %0d/%b%b%b%b expected 0/1011", count, overflow, underflow, at_max, at_zero); end
    count_dir = 1'b0;
    clk_step();
    n_tests++; if ({count, overflow, underflow} !== {8'd0, 2'b01}) begin n_fail++; $display("FAIL max0_dn: got %0d/%b%b expected 0/01", count, overflow, underflow); end
    // Legacy full-range wrap.
    max_val = 8'd255; count_dir = 1'b1;
    do_load(255);
    clk_step();
    n_tests++; if ({count, overflow} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL legacy_wrap: got %0d/%b expected 0/1", count, overflow); end
  endtask

  task automatic test_random();
    int mc, mph, mod, s, t;
    bit mo, mu, tk;
    rst = 1'b1; count_clr = 1'b0; load_en = 1'b0; clk_step(); rst = 1'b0;
    mc = 0; mph = 0;
    max_val = 8'd12; presc_div = 4'd1;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      count_clr = ($urandom_range(0, 49) == 0);
      load_en   = ($urandom_range(0, 19) == 0);
      load_val  = 8'($urandom_range(0, 255));
      count_en  = ($urandom_range(0, 7) != 0);
      count_dir = 1'($urandom_range(0, 1));
      sat_mode  = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0)
        max_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      if ($urandom_range(0, 31) == 0) presc_div = 4'($urandom_range(0, 3));
      // Reference: what the counter should hold after this edge.
      mo = 0; mu = 0;
      if (rst || count_clr) begin
        mc = 0; mph = 0;
      end else if (load_en) begin
        mc = (int'(load_val) < int'(max_val)) ? int'(load_val) : int'(max_val); mph = 0;
      end else begin
        tk = 0;
        if (count_en) begin
          if (mph >= int'(presc_div)) begin tk = 1; mph = 0; end
          else mph = mph + 1;
        end
        if (tk) begin
          mod = int'(max_val) + 1;
          s = (int'(step) < mod) ? int'(step) : mod;
          if (s == 0) begin
          end else if (mc > int'(max_val)) begin
            mo = 1; mc = sat_mode ? int'(max_val) : 0;
          end else if (count_dir) begin
            t = mc + s;
            if (t > int'(max_val)) begin mo = 1; mc = sat_mode ? int'(max_val) : t % mod; end
            else mc = t;
          end else begin
            t = mc - s;
            if (t < 0) begin mu = 1; mc = sat_mode ? 0 : t + mod; end
            else mc = t;
          end
        end
      end
      clk_step();
      n_tests++; if (count !== 8'(mc)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, count, mc); end
      n_tests++; if ({overflow, underflow} !== {mo, mu}) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b%b expected %b%b", n, overflow, underflow, mo, mu); end
      n_tests++; if ({at_max, at_zero} !== {(mc == int'(max_val)), (mc == 0)}) begin n_fail++; $display("FAIL rand_status[%0d]: got %b%b expected %b%b", n, at_max, at_zero, (mc == int'(max_val)), (mc == 0)); end
    end
    rst = 1'b0; count_clr = 1'b0; load_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_step();
    test_saturate();
    test_prescaler();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
